// File: rtl/peripheral_pkg.sv
// ============================================================================
// Module  : peripheral_pkg
// Brief   : Shared phase encoding and counter width for the peripheral
//           switch responder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package peripheral_pkg;

    typedef enum logic [1:0] {
        SILENT   = 2'd0,
        STARTING = 2'd1,
        READY    = 2'd2,
        STOPPING = 2'd3
    } peripheral_phase_e;

    localparam int PERIPHERAL_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/peripheral_sync_bit.sv
// ============================================================================
// Module  : peripheral_sync_bit
// Brief   : Multi-flop synchroniser for a single asynchronous level.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/peripheral_switch_responder.sv
// ============================================================================
// Module  : peripheral_switch_responder
// Brief   : Responder end of the request/ready/silent/starting/stopping
//           handshake; drives a physical enable with dwell and acknowledge.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_switch_responder
    import peripheral_pkg::*;
#(
    parameter int START_CYCLES   = 4,
    parameter int STOP_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int USE_ACK        = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clock,
    input  logic async_resetn,
    input  logic request,
    output logic ready,
    output logic silent,
    output logic starting,
    output logic stopping,
    output logic switch_enable,
    input  logic switch_good,
    output logic fault
);

    typedef logic [PERIPHERAL_CNT_W-1:0] cnt_t;

    localparam cnt_t c_START_LAST   = cnt_t'(START_CYCLES - 1);
    localparam cnt_t c_STOP_LAST    = cnt_t'(STOP_CYCLES - 1);
    localparam cnt_t c_TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

    peripheral_phase_e r_phase;
    cnt_t              r_cnt;
    logic              r_ready;
    logic              r_silent;
    logic              r_starting;
    logic              r_stopping;
    logic              r_switch_enable;
    logic              r_fault;

    logic w_good_sync;
    logic w_start_good;
    logic w_stop_good;
    logic w_start_done;
    logic w_stop_done;
    logic w_timeout;
    cnt_t w_cnt_inc;

    peripheral_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_good_sync (
        .clk   (clock),
        .rst_n (async_resetn),
        .i_d   (switch_good),
        .o_q   (w_good_sync)
    );

    // Without an acknowledge the resource is assumed to follow the enable.
    assign w_start_good = (USE_ACK != 0) ? w_good_sync : 1'b1;
    assign w_stop_good  = (USE_ACK != 0) ? w_good_sync : 1'b0;

    assign w_start_done = (r_cnt >= c_START_LAST) && w_start_good;
    assign w_stop_done  = (r_cnt >= c_STOP_LAST) && !w_stop_good;
    assign w_timeout    = (r_cnt == c_TIMEOUT_LAST);
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + cnt_t'(1);

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            r_phase         <= SILENT;
            r_cnt           <= '0;
            r_silent        <= 1'b1;
            r_starting      <= 1'b0;
            r_ready         <= 1'b0;
            r_stopping      <= 1'b0;
            r_switch_enable <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            case (r_phase)
                SILENT: begin
                    if (request) begin
                        r_phase         <= STARTING;
                        r_cnt           <= '0;
                        r_silent        <= 1'b0;
                        r_starting      <= 1'b1;
                        r_switch_enable <= 1'b1;
                    end
                end
                STARTING: begin
                    r_cnt <= w_cnt_inc;
                    if (w_start_done || w_timeout) begin
                        r_phase    <= READY;
                        r_starting <= 1'b0;
                        r_ready    <= 1'b1;
                        if (!w_start_done) begin
                            r_fault <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (!request) begin
                        r_phase         <= STOPPING;
                        r_cnt           <= '0;
                        r_ready         <= 1'b0;
                        r_stopping      <= 1'b1;
                        r_switch_enable <= 1'b0;
                    end
                end
                STOPPING: begin
                    r_cnt <= w_cnt_inc;
                    if (w_stop_done || w_timeout) begin
                        r_phase    <= SILENT;
                        r_stopping <= 1'b0;
                        r_silent   <= 1'b1;
                        if (!w_stop_done) begin
                            r_fault <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ready         = r_ready;
    assign silent        = r_silent;
    assign starting      = r_starting;
    assign stopping      = r_stopping;
    assign switch_enable = r_switch_enable;
    assign fault         = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_switch_responder.sv
// ============================================================================
// Module  : tb_peripheral_switch_responder
// Brief   : Scoreboard bench for three responder configurations sharing a clock.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_peripheral_switch_responder;

    localparam int P_SIL = 0;
    localparam int P_STA = 1;
    localparam int P_RDY = 2;
    localparam int P_STO = 3;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] good;
    logic [2:0] rdy, sil, sta, sto, en, flt;

    logic [5:0] sb[$];
    int         checks;
    int         failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: timing only; dut1: acknowledge; dut2: acknowledge with short timeout
    peripheral_switch_responder #(
        .USE_ACK(0)
    ) dut0 (
        .clock(clk), .async_resetn(rst_n), .request(req[0]), .ready(rdy[0]),
        .silent(sil[0]), .starting(sta[0]), .stopping(sto[0]),
        .switch_enable(en[0]), .switch_good(good[0]), .fault(flt[0])
    );

    peripheral_switch_responder #(
        .USE_ACK(1)
    ) dut1 (
        .clock(clk), .async_resetn(rst_n), .request(req[1]), .ready(rdy[1]),
        .silent(sil[1]), .starting(sta[1]), .stopping(sto[1]),
        .switch_enable(en[1]), .switch_good(good[1]), .fault(flt[1])
    );

    peripheral_switch_responder #(
        .USE_ACK(1),
        .TIMEOUT_CYCLES(16)
    ) dut2 (
        .clock(clk), .async_resetn(rst_n), .request(req[2]), .ready(rdy[2]),
        .silent(sil[2]), .starting(sta[2]), .stopping(sto[2]),
        .switch_enable(en[2]), .switch_good(good[2]), .fault(flt[2])
    );

    // Observation vector: {silent, starting, ready, stopping, switch_enable, fault}
    function automatic logic [5:0] ev(input int ph, input bit f);
        case (ph)
            P_STA:   return {4'b0100, 1'b1, f};
            P_RDY:   return {4'b0010, 1'b1, f};
            P_STO:   return {4'b0001, 1'b0, f};
            default: return {4'b1000, 1'b0, f};
        endcase
    endfunction

    function automatic logic [5:0] get(input int s);
        return {sil[s], sta[s], rdy[s], sto[s], en[s], flt[s]};
    endfunction

    task automatic push(input int ph, input bit f, input int n);
        for (int k = 0; k < n; k++) sb.push_back(ev(ph, f));
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic test_reset();
        logic [5:0] o;
        rst_n = 1'b0;
        req   = '0;
        good  = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            o = get(s);
            checks++;
            if (o !== ev(P_SIL, 1'b0)) begin
                failures++;
                $display("FAIL reset dut%0d got=%b exp=%b", s, o, ev(P_SIL, 1'b0));
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        o = get(0);
        checks++;
        if (o !== ev(P_SIL, 1'b0)) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=%b", o, ev(P_SIL, 1'b0));
        end
    endtask

    task automatic test_start_timing();
        logic [5:0] o, e;
        push(P_STA, 0, 4);
        push(P_RDY, 0, 3);
        push(P_STO, 0, 4);
        push(P_SIL, 0, 1);
        req[0] = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = get(0);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL start_timing cyc=%0d got=%b exp=%b", i, o, e);
            end
            if (i == 6) req[0] = 1'b0;
        end
    endtask

    task automatic test_pulse();
        logic [5:0] o, e;
        push(P_STA, 0, 4);
        push(P_RDY, 0, 1);
        push(P_STO, 0, 4);
        push(P_SIL, 0, 2);
        req[0] = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = get(0);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pulse cyc=%0d got=%b exp=%b", i, o, e);
            end
            if (i == 0) req[0] = 1'b0;
        end
    endtask

    task automatic test_restart_in_stopping();
        logic [5:0] o, e;
        push(P_STA, 0, 4);
        push(P_RDY, 0, 1);
        push(P_STO, 0, 4);
        push(P_SIL, 0, 1);
        push(P_STA, 0, 4);
        push(P_RDY, 0, 1);
        push(P_STO, 0, 4);
        push(P_SIL, 0, 1);
        req[0] = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = get(0);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL restart_stopping cyc=%0d got=%b exp=%b", i, o, e);
            end
            if (i == 4)  req[0] = 1'b0;
            if (i == 6)  req[0] = 1'b1;
            if (i == 14) req[0] = 1'b0;
        end
    endtask

    task automatic test_ack();
        logic [5:0] o, e;
        push(P_STA, 0, 12);
        push(P_RDY, 0, 3);
        push(P_STO, 0, 4);
        push(P_SIL, 0, 1);
        req[1] = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = get(1);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ack cyc=%0d got=%b exp=%b", i, o, e);
            end
            if (i == 9)  good[1] = 1'b1;
            if (i == 12) good[1] = 1'b0;
            if (i == 14) req[1]  = 1'b0;
        end
    endtask

    task automatic test_timeout();
        logic [5:0] o, e;
        push(P_STA, 0, 16);
        push(P_RDY, 1, 1);
        push(P_STO, 1, 4);
        push(P_SIL, 1, 1);
        push(P_STA, 1, 16);
        push(P_RDY, 1, 1);
        req[2] = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = get(2);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL timeout cyc=%0d got=%b exp=%b", i, o, e);
            end
            if (i == 16) req[2] = 1'b0;
            if (i == 21) req[2] = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        o = get(2);
        checks++;
        if (o !== ev(P_SIL, 1'b0)) begin
            failures++;
            $display("FAIL fault_clear got=%b exp=%b", o, ev(P_SIL, 1'b0));
        end
        req[2] = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_start();
        logic [5:0] o, e;
        push(P_STA, 0, 2);
        req[0] = 1'b1;
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = get(0);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mid_start_pre cyc=%0d got=%b exp=%b", i, o, e);
            end
        end
        rst_n = 1'b0;
        #1;
        o = get(0);
        checks++;
        if (o !== ev(P_SIL, 1'b0)) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", o, ev(P_SIL, 1'b0));
        end
        #2;
        rst_n = 1'b1;
        push(P_STA, 0, 4);
        push(P_RDY, 0, 1);
        push(P_STO, 0, 4);
        push(P_SIL, 0, 1);
        for (int i = 0; sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = get(0);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mid_start_post cyc=%0d got=%b exp=%b", i, o, e);
            end
            if (i == 4) req[0] = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = '0;
        good     = '0;
        test_reset();
        test_start_timing();
        test_pulse();
        test_restart_in_stopping();
        test_ack();
        test_timeout();
        test_reset_mid_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
